rpi_spi_regif: RTL

Parametrised SPI slave register port between the Raspberry Pi SPI0 master and the FPGA register file. It supports all four SPI modes, generic address and data widths, and a bounded command/address/data frame. Optionally it supports multi-word burst transfers with address auto-increment. It drives single-cycle read and write strobes into the `clk` domain, and all SPI pins are synchronised internally.

---
 rtl/rpi_spi_regif_if.sv | 22 ++
 rtl/rpi_spi_regif.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rpi_spi_regif_if.sv
// Register-file side of the Raspberry Pi SPI register port: strobes, address,
// write data out and read data back.
interface rpi_spi_regif_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) ();
  logic              reg_read_stb;
  logic              reg_write_stb;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_write_data;
  logic [DATA_W-1:0] spi_read_data;

  modport master (
    output reg_read_stb, reg_write_stb, spi_addr, spi_write_data,
    input  spi_read_data
  );

  modport slave (
    input  reg_read_stb, reg_write_stb, spi_addr, spi_write_data,
    output spi_read_data
  );
endinterface

// File: rtl/rpi_spi_regif.sv
// SPI slave register port (R/W bit, address, data; all four SPI modes) driving
// single-cycle register strobes in the clk domain. Define RPI_SPI_BURST_EN for
// multi-word bursts with address auto-increment.
module rpi_spi_regif #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs0_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  output wire  spi_miso,
  output logic frame_err,
  output logic busy,
  rpi_spi_regif_if.master regbus
);
  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              part_q, part_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic              addr_ld, word_done;
  logic [ADDR_W-1:0] addr_q, addr_sh_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, data_sh_q, data_nx, tx_q;
  logic              miso_oe_q, miso_q;

  logic cs_p0, cs_p1, cs_p2;
  logic sck_p0, sck_p1, sck_p2;
  logic mosi_p0, mosi_p1;

  // Stage p0/p1: two-FF synchronisers; p2: delayed copy for edge detection.
  // CS resets to "selected" so a release mid-frame never fakes a CS fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      cs_p2   <= 1'b0;
      sck_p0  <= CPOL;
      sck_p1  <= CPOL;
      sck_p2  <= CPOL;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      cs_p0   <= spi_cs0_n;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      sck_p0  <= spi_clk;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  logic sck_rise, sck_fall, lead_edge, trail_edge, samp_edge, shift_edge;
  logic cs_fall, cs_rise, samp;

  assign sck_rise   = sck_p1 & ~sck_p2;
  assign sck_fall   = ~sck_p1 & sck_p2;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign samp_edge  = CPHA ? trail_edge : lead_edge;
  assign shift_edge = CPHA ? lead_edge : trail_edge;
  assign cs_fall    = ~cs_p1 & cs_p2;
  assign cs_rise    = cs_p1 & ~cs_p2;
  assign samp       = samp_edge && (state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA);
  assign addr_nx    = ADDR_W'({addr_sh_q, mosi_p1});
  assign data_nx    = DATA_W'({data_sh_q, mosi_p1});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    part_d    = part_q | samp;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    err_d     = 1'b0;
    addr_ld   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: if (cs_fall) begin
        state_d = S_CMD;
        cnt_d   = '0;
        part_d  = 1'b0;
      end
      S_CMD: if (samp) begin
        rw_d    = mosi_p1;
        state_d = S_ADDR;
        cnt_d   = '0;
      end
      S_ADDR: if (samp) begin
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          addr_ld  = 1'b1;
          rd_stb_d = rw_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: if (samp) begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          word_done = 1'b1;
          part_d    = 1'b0;
          cnt_d     = '0;
          wr_stb_d  = ~rw_q;
`ifdef RPI_SPI_BURST_EN
          rd_stb_d  = rw_q;
`else
          state_d   = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // A word completing on the CS-rise cycle has already cleared part_d.
    if (cs_rise && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = (state_q != S_DONE) && part_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      part_q    <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      miso_oe_q <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      part_q   <= part_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
      if (addr_ld) begin
        addr_q <= addr_nx;
`ifdef RPI_SPI_BURST_EN
      // Reads advance with the strobe; writes advance once their strobe is gone.
      end else if ((word_done && rw_q) || wr_stb_q) begin
        addr_q <= addr_q + 1'b1;
`endif
      end
      if (word_done && !rw_q) wdata_q <= data_nx;
      if (state_d == S_IDLE) begin
        miso_oe_q <= 1'b0;
        miso_q    <= 1'b0;
      end else if (shift_edge && rw_q && (state_q == S_DATA || state_q == S_DONE)) begin
        miso_oe_q <= 1'b1;
        miso_q    <= (state_q == S_DONE) ? 1'b0 : tx_q[DATA_W-1];
      end
    end
  end

  // Shift registers carry only data; control above decides when they matter.
  always_ff @(posedge clk) begin
    if (samp && state_q == S_ADDR) addr_sh_q <= addr_nx;
    if (samp && state_q == S_DATA) data_sh_q <= data_nx;
    if (rd_stb_q) tx_q <= regbus.spi_read_data;
    else if (shift_edge && state_q == S_DATA) tx_q <= tx_q << 1;
  end

  assign spi_miso              = miso_oe_q ? miso_q : 1'bz;
  assign frame_err             = err_q;
  assign busy                  = busy_q;
  assign regbus.reg_read_stb   = rd_stb_q;
  assign regbus.reg_write_stb  = wr_stb_q;
  assign regbus.spi_addr       = addr_q;
  assign regbus.spi_write_data = wdata_q;
endmodule
